// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter: three producers share one register-file write port.
// One transfer per non-hold cycle; the write appears registered in the following cycle.
module rf_wb_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_valid,
  input  logic [3*AW-1:0] req_rd,
  input  logic [3*DW-1:0] req_wd,
  output logic [2:0]      req_ready,
  input  logic            hold,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [DW-1:0]   rf_wd,
  output logic [1:0]      last_grant
);

  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    ptr_norm;
  logic [2:0]    grant;
  logic [1:0]    gidx;
  logic          granted;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_wd;

  logic          rf_we_q;
  logic [AW-1:0] rf_rd_q;
  logic [DW-1:0] rf_wd_q;
  logic [1:0]    last_grant_q;

  // The unused encoding 3 is treated as 0 so the pointer can never lock up.
  assign ptr_norm = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

  // Search requesters in order ptr, ptr+1, ptr+2 (mod 3); first valid one wins.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] idx;
    grant = 3'b000;
    gidx  = 2'd0;
    sum   = 3'd0;
    idx   = 2'd0;
    if (!rst && !hold) begin
      for (int k = 0; k < 3; k++) begin
        sum = {1'b0, ptr_norm} + 3'(k);
        idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        if (grant == 3'b000 && req_valid[idx]) begin
          grant[idx] = 1'b1;
          gidx       = idx;
        end
      end
    end
  end

  assign granted   = (grant != 3'b000);
  assign req_ready = grant;

  always_comb begin
    sel_rd = req_rd[AW-1:0];
    sel_wd = req_wd[DW-1:0];
    unique case (gidx)
      2'd1: begin
        sel_rd = req_rd[2*AW-1:AW];
        sel_wd = req_wd[2*DW-1:DW];
      end
      2'd2: begin
        sel_rd = req_rd[3*AW-1:2*AW];
        sel_wd = req_wd[3*DW-1:2*DW];
      end
      default: begin
        sel_rd = req_rd[AW-1:0];
        sel_wd = req_wd[DW-1:0];
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_norm;
    if (granted) begin
      ptr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= 2'd0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wd_q      <= '0;
      last_grant_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
      if (granted) begin
        // Writes to $0 still complete the handshake but never reach the file.
        rf_we_q      <= (sel_rd != '0);
        rf_rd_q      <= sel_rd;
        rf_wd_q      <= sel_wd;
        last_grant_q <= gidx;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wd      = rf_wd_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random traffic,
// compared against a behavioural round-robin model.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_rd;
  logic [3*DW-1:0] req_wd;
  logic [2:0]      req_ready;
  logic            hold;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [DW-1:0]   rf_wd;
  logic [1:0]      last_grant;

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_wd    (req_wd),
    .req_ready (req_ready),
    .hold      (hold),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Pending requests (held stable until accepted) and model state.
  logic [2:0]    pv;
  logic [AW-1:0] prd[3];
  logic [DW-1:0] pwd[3];
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wd;
  int            m_lg;
  int            waits[3];
  int            glog[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic int pick(input logic [2:0] v, input logic h, input int p);
    if (h) return -1;
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_rd = '0; m_wd = '0; m_lg = 3;
    pv = 3'b000;
    for (int i = 0; i < 3; i++) begin
      prd[i] = '0; pwd[i] = '0; waits[i] = 0;
    end
  endtask

  // One clock: drive, check ready, advance model, check registered outputs.
  task automatic cycle(input logic h);
    int g;
    logic [2:0] exp_ready;
    req_valid = pv;
    hold      = h;
    req_rd    = {prd[2], prd[1], prd[0]};
    req_wd    = {pwd[2], pwd[1], pwd[0]};
    #1;
    g = pick(pv, h, m_ptr);
    exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      chk("fairness", 64'(waits[g] <= 2), 64'd1);
      m_we  = (prd[g] != '0);
      m_rd  = prd[g];
      m_wd  = pwd[g];
      m_lg  = g;
      m_ptr = (g + 1) % 3;
      pv[g] = 1'b0;
      waits[g] = 0;
      glog.push_back(g);
    end else begin
      m_we = 1'b0;
    end
    if (!h) begin
      for (int i = 0; i < 3; i++) if (pv[i]) waits[i]++;
    end
    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_rd", 64'(rf_rd), 64'(m_rd));
    chk("rf_wd", 64'(rf_wd), 64'(m_wd));
    chk("last_grant", 64'(last_grant), 64'(m_lg));
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] wd);
    pv[i]  = 1'b1;
    prd[i] = rd;
    pwd[i] = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_rf_wd", 64'(rf_wd), 64'd0);
    chk("rst_last_grant", 64'(last_grant), 64'd3);
    chk("rst_ready", 64'(req_ready), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; hold = 1'b0; req_valid = '0; req_rd = '0; req_wd = '0;
    model_reset();
    // Drive valid requests during reset: ready must still be zero.
    req_valid = 3'b111;
    #2;
    do_reset();

    // All three valid, each drops once accepted.
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    repeat (3) cycle(1'b0);
    cycle(1'b0);

    // Write to $0: handshake completes, no write.
    set_req(1, 5'd0, 32'hDEAD);
    cycle(1'b0);
    cycle(1'b0);

    // Hold blocks requests for 4 cycles.
    set_req(0, 5'd9, 32'h900);
    set_req(2, 5'd10, 32'hA00);
    repeat (4) cycle(1'b1);
    repeat (3) cycle(1'b0);

    // Reset between tests so the pointer starts at 0, then same-Rd contention.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      set_req(0, 5'd5, 32'hA);
      set_req(2, 5'd5, 32'hB);
      cycle(1'b0);
    end
    pv = 3'b000;
    cycle(1'b0);

    // Reset right after a requester-2 transfer is accepted.
    set_req(2, 5'd7, 32'h77);
    cycle(1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_rf_we", 64'(rf_we), 64'd0);
    chk("rst_async_last_grant", 64'(last_grant), 64'd3);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cycle(1'b0);

    // First grant after reset comes from requester 0.
    set_req(0, 5'd4, 32'h44);
    set_req(1, 5'd6, 32'h66);
    set_req(2, 5'd8, 32'h88);
    cycle(1'b0);
    chk("first_after_rst", 64'(last_grant), 64'd0);
    repeat (2) cycle(1'b0);

    // Random traffic: requests stay stable until accepted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] && ($urandom % 2 == 0)) begin
          set_req(i, ($urandom % 4 == 0) ? '0 : AW'($urandom), $urandom);
        end
      end
      cycle(($urandom % 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
